lsu_pfu_gsdb_stride_det: RTL and testbench

Global stride detector for the LSU prefetch unit. It watches prefetch-eligible loads in the DA stage and learns a constant address stride from consecutive accesses. Once the stride is confirmed, it issues a one-cycle create request with the stride to the global prefetch buffer (gpfb), which sits directly downstream. It also requests a gpfb pop when the stream breaks.

---
 rtl/lsu_pfu_gsdb_stride_det.sv | 189 ++++++++++++++++++
 tb/tb_lsu_pfu_gsdb_stride_det.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pfu_gsdb_stride_det.sv
// rtl/lsu_pfu_gsdb_stride_det.sv - global stride detector for the LSU prefetch unit (option: PFU_GSDB_PAGE_CROSS_CHK_EN)
module lsu_pfu_gsdb_stride_det #(
  parameter int CONF_THRESH = 2,
  parameter int MISS_THRESH = 2
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        cp0_lsu_icg_en,
  input  logic        pad_yy_icg_scan_en,
  input  logic        ld_da_pfu_act_vld,
  input  logic        ld_da_pfu_pf_inst_vld,
  input  logic [39:0] ld_da_pfu_va,
  input  logic        pfu_gpfb_vld,
  input  logic        pfu_pop_all_vld,
  output logic        pfu_gsdb_gpfb_create_vld,
  output logic [10:0] pfu_gsdb_stride,
  output logic        pfu_gsdb_stride_neg,
  output logic [6:0]  pfu_gsdb_strideh_6to0,
  output logic        pfu_gsdb_gpfb_pop_req
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] CONF_T = 2'(CONF_THRESH);
  localparam logic [1:0] MISS_T = 2'(MISS_THRESH);

  state_t      state_q, state_d;
  logic [39:0] last_va_q, last_va_d;
  logic [10:0] stride_q, stride_d;
  logic        stride_vld_q, stride_vld_d;
  logic [1:0]  conf_q, conf_d;
  logic [1:0]  miss_q, miss_d;
  logic        create_q, create_d;
  logic        pop_q, pop_d;
  logic        gpfb_vld_q;

  logic        access;
  logic [39:0] delta;
  logic        delta_vld;
  logic        delta_match;
  logic        evict;
  logic        create_pending;
  logic        learn_en;
  logic [1:0]  conf_inc;
  logic [1:0]  miss_inc;

  assign access = ld_da_pfu_act_vld & ld_da_pfu_pf_inst_vld;
  assign delta  = ld_da_pfu_va - last_va_q;

  // A delta is usable only if it fits the signed 11-bit stride range and is non-zero
`ifdef PFU_GSDB_PAGE_CROSS_CHK_EN
  assign delta_vld = ((&delta[39:10]) | ~(|delta[39:10])) & (|delta)
                   & (ld_da_pfu_va[39:12] == last_va_q[39:12]);
`else
  assign delta_vld = ((&delta[39:10]) | ~(|delta[39:10])) & (|delta);
`endif

  assign delta_match    = delta_vld & stride_vld_q & (delta[10:0] == stride_q);
  // The gpfb entry disappeared without us asking: detected on its falling edge
  assign evict          = (state_q == ACTIVE) & gpfb_vld_q & ~pfu_gpfb_vld;
  assign create_pending = (state_q == TRAIN) & (conf_q == CONF_T);
  assign conf_inc       = (conf_q >= CONF_T) ? conf_q : conf_q + 2'd1;
  assign miss_inc       = miss_q + 2'd1;

  // Learning registers only move on these events; scan or a disabled ICG keeps them always clocked
  assign learn_en = access | pfu_pop_all_vld | create_pending | evict
                  | ~cp0_lsu_icg_en | pad_yy_icg_scan_en;

  // Next-state and pulse decisions; pop_all overrides everything last
  always_comb begin
    state_d      = state_q;
    last_va_d    = last_va_q;
    stride_d     = stride_q;
    stride_vld_d = stride_vld_q;
    conf_d       = conf_q;
    miss_d       = miss_q;
    create_d     = 1'b0;
    pop_d        = 1'b0;

    if (access) begin
      last_va_d = ld_da_pfu_va;
    end

    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = TRAIN;
        end
      end
      TRAIN: begin
        if (access) begin
          if (!delta_vld) begin
            stride_vld_d = 1'b0;
            conf_d       = 2'd0;
          end else if (delta_match) begin
            conf_d = conf_inc;
          end else begin
            stride_d     = delta[10:0];
            stride_vld_d = 1'b1;
            conf_d       = 2'd0;
          end
        end
        if (stride_vld_d && (conf_d == CONF_T) && !pfu_gpfb_vld) begin
          create_d = 1'b1;
          state_d  = ACTIVE;
          miss_d   = 2'd0;
        end
      end
      ACTIVE: begin
        if (evict) begin
          state_d      = TRAIN;
          stride_vld_d = 1'b1;
          conf_d       = 2'd0;
          miss_d       = 2'd0;
        end else if (access) begin
          if (delta_match) begin
            miss_d = 2'd0;
          end else if (miss_inc == MISS_T) begin
            pop_d        = 1'b1;
            state_d      = TRAIN;
            stride_vld_d = 1'b0;
            conf_d       = 2'd0;
            miss_d       = 2'd0;
          end else begin
            miss_d = miss_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pfu_pop_all_vld) begin
      state_d      = IDLE;
      last_va_d    = 40'd0;
      stride_d     = 11'd0;
      stride_vld_d = 1'b0;
      conf_d       = 2'd0;
      miss_d       = 2'd0;
      create_d     = 1'b0;
      pop_d        = 1'b0;
    end
  end

  // Always-clocked control: state, output pulses and the gpfb_vld edge sample
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= IDLE;
      create_q   <= 1'b0;
      pop_q      <= 1'b0;
      gpfb_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      create_q   <= create_d;
      pop_q      <= pop_d;
      gpfb_vld_q <= pfu_gpfb_vld;
    end
  end

  // Gated learning registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      last_va_q    <= 40'd0;
      stride_q     <= 11'd0;
      stride_vld_q <= 1'b0;
      conf_q       <= 2'd0;
      miss_q       <= 2'd0;
    end else if (learn_en) begin
      last_va_q    <= last_va_d;
      stride_q     <= stride_d;
      stride_vld_q <= stride_vld_d;
      conf_q       <= conf_d;
      miss_q       <= miss_d;
    end
  end

  assign pfu_gsdb_gpfb_create_vld = create_q;
  assign pfu_gsdb_gpfb_pop_req    = pop_q;
  assign pfu_gsdb_stride          = stride_q;
  assign pfu_gsdb_stride_neg      = stride_q[10];
  // Magnitude is 11-bit unsigned so -1024 maps to 0x400 without overflow
  assign pfu_gsdb_strideh_6to0    = 7'((stride_q[10] ? (11'd0 - stride_q) : stride_q) >> 4);

endmodule

// File: tb/tb_lsu_pfu_gsdb_stride_det.sv
// tb/tb_lsu_pfu_gsdb_stride_det.sv - randomized model-checked bench for lsu_pfu_gsdb_stride_det
module tb_lsu_pfu_gsdb_stride_det;

  localparam int CONF = 2;
  localparam int MISS = 2;
  localparam longint MASK40 = (longint'(1) << 40) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icg_en, scan_en, act, pfv, gvld, pall;
  logic [39:0] va;
  logic        create, neg, pop;
  logic [10:0] stride;
  logic [6:0]  strideh;

  int n_chk = 0;
  int n_err = 0;

  // reference model: stride held as a signed integer, states as small ints
  int     m_state;
  longint m_last, m_stride;
  bit     m_svld, m_create, m_pop, m_gq;
  int     m_conf, m_miss;

  lsu_pfu_gsdb_stride_det dut (
    .forever_cpuclk           (clk),
    .cpurst_b                 (rst_n),
    .cp0_lsu_icg_en           (icg_en),
    .pad_yy_icg_scan_en       (scan_en),
    .ld_da_pfu_act_vld        (act),
    .ld_da_pfu_pf_inst_vld    (pfv),
    .ld_da_pfu_va             (va),
    .pfu_gpfb_vld             (gvld),
    .pfu_pop_all_vld          (pall),
    .pfu_gsdb_gpfb_create_vld (create),
    .pfu_gsdb_stride          (stride),
    .pfu_gsdb_stride_neg      (neg),
    .pfu_gsdb_strideh_6to0    (strideh),
    .pfu_gsdb_gpfb_pop_req    (pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = 0; m_stride = 0; m_svld = 0;
    m_conf = 0; m_miss = 0; m_create = 0; m_pop = 0; m_gq = 0;
  endtask

  task automatic model_step();
    bit     acc, dv;
    longint diff, d;
    acc  = act && pfv;
    diff = (longint'(va) - m_last) & MASK40;
    d    = (diff >= (longint'(1) << 39)) ? diff - (longint'(1) << 40) : diff;
    dv   = (d != 0) && (d >= -1024) && (d <= 1023);
`ifdef PFU_GSDB_PAGE_CROSS_CHK_EN
    if ((longint'(va) >> 12) != (m_last >> 12)) dv = 0;
`endif
    m_create = 0;
    m_pop    = 0;
    if (pall) begin
      m_state = 0; m_last = 0; m_stride = 0; m_svld = 0; m_conf = 0; m_miss = 0;
    end else begin
      if (m_state == 0) begin
        if (acc) m_state = 1;
      end else if (m_state == 1) begin
        if (acc) begin
          if (!dv) begin
            m_svld = 0; m_conf = 0;
          end else if (m_svld && d == m_stride) begin
            m_conf = (m_conf + 1 > CONF) ? CONF : m_conf + 1;
          end else begin
            m_stride = d; m_svld = 1; m_conf = 0;
          end
        end
        if (m_svld && m_conf == CONF && !gvld) begin
          m_create = 1; m_state = 2; m_miss = 0;
        end
      end else begin
        if (m_gq && !gvld) begin
          m_state = 1; m_conf = 0; m_miss = 0;
        end else if (acc) begin
          if (dv && d == m_stride) m_miss = 0;
          else m_miss++;
          if (m_miss == MISS) begin
            m_pop = 1; m_state = 1; m_svld = 0; m_conf = 0; m_miss = 0;
          end
        end
      end
      if (acc) m_last = longint'(va);
    end
    m_gq = gvld;
  endtask

  task automatic check_outputs();
    longint mag;
    mag = (m_stride < 0) ? -m_stride : m_stride;
    chk("create", create, m_create);
    chk("pop", pop, m_pop);
    chk("stride", stride, m_stride & 11'h7FF);
    chk("neg", neg, m_stride < 0);
    chk("strideh", strideh, (mag >> 4) & 7'h7F);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic access(input logic [39:0] a);
    act = 1; pfv = 1; va = a;
    cycle();
    act = 0;
  endtask

  task automatic idle_c(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flush();
    pall = 1;
    cycle();
    pall = 0;
  endtask

  initial begin
    logic [39:0] cur_va;
    longint      cur_stride;
    longint      stride_tab [11];
    stride_tab = '{64, -64, 256, -1024, 1024, 0, 8, -8, 1023, -1, 4096};

    icg_en = 1; scan_en = 0; act = 0; pfv = 0; va = 0; gvld = 0; pall = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;

    // ascending 0x40 stream
    access(40'h1000); access(40'h1040); access(40'h1080); access(40'h10C0);
    chk("tp1_create", create, 1);
    chk("tp1_stride", stride, 11'h040);
    chk("tp1_strideh", strideh, 7'h04);
    gvld = 1;
    idle_c(1);
    chk("tp1_pulse_width", create, 0);

    // two misses in ACTIVE
    access(40'h11C0); access(40'h12C0);
    chk("tp3_pop", pop, 1);
    chk("tp3_no_create", create, 0);
    idle_c(1);
    gvld = 0;
    flush();

    // descending stream, then asynchronous reset mid-pulse
    access(40'h2000); access(40'h1FC0); access(40'h1F80); access(40'h1F40);
    chk("tp2_create", create, 1);
    chk("tp2_stride", stride, 11'h7C0);
    chk("tp2_neg", neg, 1);
    chk("tp2_strideh", strideh, 7'h04);
    #1 rst_n = 0;
    #1 chk("rst_create", create, 0);
    chk("rst_stride", stride, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // threshold reached while the gpfb is busy
    gvld = 1;
    access(40'h3000); access(40'h3100); access(40'h3200); access(40'h3300);
    chk("tp4_held", create, 0);
    idle_c(2);
    gvld = 0;
    idle_c(1);
    chk("tp4_create", create, 1);
    chk("tp4_stride", stride, 11'h100);

    // eviction in ACTIVE keeps the stride
    gvld = 1;
    idle_c(1);
    gvld = 0;
    idle_c(1);
    chk("evict_no_pop", pop, 0);
    access(40'h3400); access(40'h3500);
    chk("evict_recreate", create, 1);
    flush();

    // out-of-range and zero deltas, then the -1024 boundary
    access(40'h5000); access(40'h5400); access(40'h5800); access(40'h5C00);
    access(40'h5C00); access(40'h5C00);
    chk("tp5_no_create", create, 0);
    flush();
    access(40'h8000); access(40'h7C00); access(40'h7800); access(40'h7400);
    chk("tp5_neg1024_create", create, 1);
    chk("tp5_neg1024_strideh", strideh, 7'h40);
    chk("tp5_neg1024_stride", stride, 11'h400);
    flush();

    // pop_all with the confirming access
    access(40'h9000); access(40'h9040); access(40'h9080);
    pall = 1;
    access(40'h90C0);
    pall = 0;
    chk("tp6_suppressed", create, 0);
    idle_c(1);
    chk("tp6_still_none", create, 0);

    // stream starting just below a page boundary
    access(40'h0FC0); access(40'h1000); access(40'h1040); access(40'h1080);
    access(40'h10C0); access(40'h1100);
    flush();

    // randomized streams
    cur_va = 40'h10_0000;
    cur_stride = 64;
    for (int i = 0; i < 3000; i++) begin
      if (m_create) gvld = ($urandom % 4) != 0;
      else if (m_pop) gvld = 0;
      else if (($urandom % 32) == 0) gvld = ~gvld;
      pall    = ($urandom % 64) == 0;
      icg_en  = ($urandom % 8) != 0;
      scan_en = ($urandom % 16) == 0;
      act     = ($urandom % 4) != 0;
      pfv     = ($urandom % 8) != 0;
      if (($urandom % 24) == 0) cur_stride = stride_tab[$urandom % 11];
      if (($urandom % 40) == 0) cur_va = {8'($urandom), 32'($urandom)};
      va = cur_va;
      if (($urandom % 20) == 0) va = va + 40'd8;
      if (act && pfv) cur_va = cur_va + 40'(cur_stride);
      cycle();
      chk("rand_excl", create & pop, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
